// File: rtl/stream_result_checker.sv
// rtl/stream_result_checker.sv - ordered expected-vs-result checker with FIFO, counters and halt
// Optional feature macro: CHECKER_MASK_EN (per-entry compare mask stored alongside each expected value).
module stream_result_checker #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     exp_valid_i,
    input  logic [DATA_W-1:0]        exp_data_i,
`ifdef CHECKER_MASK_EN
    input  logic [DATA_W-1:0]        exp_mask_i,
`endif
    output logic                     exp_ready_o,
    input  logic                     res_valid_i,
    input  logic [DATA_W-1:0]        res_data_i,
    output logic                     correct_o,
    output logic                     mismatch_o,
    output logic                     underflow_o,
    output logic                     halted_o,
    output logic [CNT_W-1:0]         match_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic [$clog2(DEPTH):0]   pending_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ERR_LIM_C = CNT_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               correct_q, correct_d;
    logic               mismatch_q, mismatch_d;
    logic               underflow_q, underflow_d;

    logic [DATA_W-1:0]  data_mem_q [DEPTH];
`ifdef CHECKER_MASK_EN
    logic [DATA_W-1:0]  mask_mem_q [DEPTH];
`endif

    logic               in_check;
    logic               fifo_empty;
    logic               pop_avail;
    logic               push_en;
    logic               pop_en;
    logic               res_en;
    logic               head_match;
    logic [DATA_W-1:0]  head_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign in_check   = (state_q == ST_CHECK);
    assign fifo_empty = (count_q == '0);
    // A same-cycle pop frees a slot, so a full FIFO can still take a push.
    assign pop_avail  = in_check && res_valid_i && !fifo_empty;
    assign exp_ready_o = in_check && ((count_q != DEPTH_C) || pop_avail);

    // start_i wins over any traffic presented on the same edge.
    assign push_en = exp_valid_i && exp_ready_o && !start_i;
    assign pop_en  = pop_avail && !start_i;
    assign res_en  = in_check && res_valid_i && !start_i;

    assign head_data = data_mem_q[rd_ptr_q];
`ifdef CHECKER_MASK_EN
    assign head_match = (((res_data_i ^ head_data) & mask_mem_q[rd_ptr_q]) == '0);
`else
    assign head_match = (res_data_i == head_data);
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        underflow_d = underflow_q;
        correct_d   = 1'b0;
        mismatch_d  = 1'b0;

        if (start_i) begin
            state_d     = ST_CHECK;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            underflow_d = 1'b0;
        end else if (in_check) begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase

            if (res_en) begin
                if (pop_en && head_match) begin
                    correct_d   = 1'b1;
                    match_cnt_d = sat_inc(match_cnt_q);
                end else begin
                    // Either a compare failure or a result with nothing queued.
                    mismatch_d = 1'b1;
                    err_cnt_d  = sat_inc(err_cnt_q);
                    if (fifo_empty) underflow_d = 1'b1;
                    if ((ERR_LIMIT != 0) && (err_cnt_d == ERR_LIM_C)) state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            correct_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            correct_q   <= correct_d;
            mismatch_q  <= mismatch_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            data_mem_q[wr_ptr_q] <= exp_data_i;
`ifdef CHECKER_MASK_EN
            mask_mem_q[wr_ptr_q] <= exp_mask_i;
`endif
        end
    end

    assign correct_o   = correct_q;
    assign mismatch_o  = mismatch_q;
    assign underflow_o = underflow_q;
    assign halted_o    = (state_q == ST_HALT);
    assign match_cnt_o = match_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign pending_o   = count_q;

endmodule

// File: tb/tb_stream_result_checker.sv
// tb/tb_stream_result_checker.sv - self-checking bench: two checker instances against a queue model
module tb_stream_result_checker;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ev = 1'b0;
    logic [DW-1:0] ed = '0;
    logic          rv = 1'b0;
    logic [DW-1:0] rd = '0;
`ifdef CHECKER_MASK_EN
    logic [DW-1:0] em = '1;
`endif

    logic          rdy_a, cor_a, mis_a, und_a, hlt_a;
    logic [15:0]   mc_a, ec_a;
    logic [3:0]    pend_a;
    logic          rdy_b, cor_b, mis_b, und_b, hlt_b;
    logic [3:0]    mc_b, ec_b;
    logic [3:0]    pend_b;

    always #5 clk = ~clk;

    stream_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16), .ERR_LIMIT(1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .exp_valid_i(ev), .exp_data_i(ed),
`ifdef CHECKER_MASK_EN
        .exp_mask_i(em),
`endif
        .exp_ready_o(rdy_a), .res_valid_i(rv), .res_data_i(rd),
        .correct_o(cor_a), .mismatch_o(mis_a), .underflow_o(und_a), .halted_o(hlt_a),
        .match_cnt_o(mc_a), .err_cnt_o(ec_a), .pending_o(pend_a)
    );

    stream_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(4), .ERR_LIMIT(0)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .exp_valid_i(ev), .exp_data_i(ed),
`ifdef CHECKER_MASK_EN
        .exp_mask_i(em),
`endif
        .exp_ready_o(rdy_b), .res_valid_i(rv), .res_data_i(rd),
        .correct_o(cor_b), .mismatch_o(mis_b), .underflow_o(und_b), .halted_o(hlt_b),
        .match_cnt_o(mc_b), .err_cnt_o(ec_b), .pending_o(pend_b)
    );

    // Reference model: instance 0 = u_dut_a, instance 1 = u_dut_b.
    // Queue entries hold {mask, data}; mode 0 idle, 1 checking, 2 halted.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int m_mode[2]  = '{0, 0};
    int m_match[2] = '{0, 0};
    int m_err[2]   = '{0, 0};
    bit m_cor[2]   = '{0, 0};
    bit m_mis[2]   = '{0, 0};
    bit m_und[2]   = '{0, 0};
    int m_limit[2] = '{1, 0};
    int m_max[2]   = '{65535, 15};

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    function automatic int qsize(int k);
        return (k == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [31:0] qpop(int k);
        if (k == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic void qpush(int k, logic [31:0] v);
        if (k == 0) qa.push_back(v);
        else        qb.push_back(v);
    endfunction

    function automatic void model_clear(int k, int mode);
        if (k == 0) qa.delete();
        else        qb.delete();
        m_mode[k] = mode;
        m_match[k] = 0; m_err[k] = 0;
        m_cor[k] = 0; m_mis[k] = 0; m_und[k] = 0;
    endfunction

    function automatic void model_update(int k, bit s, bit e, logic [31:0] entry,
                                         bit r, logic [15:0] res, bit rdy);
        logic [31:0] h;
        bit bad;
        if (s) begin
            model_clear(k, 1);
        end else if (m_mode[k] == 1) begin
            m_cor[k] = 0; m_mis[k] = 0; bad = 0;
            if (r) begin
                if (qsize(k) > 0) begin
                    h = qpop(k);
                    if (((h[15:0] ^ res) & h[31:16]) == 16'h0) begin
                        m_cor[k] = 1;
                        if (m_match[k] < m_max[k]) m_match[k]++;
                    end else bad = 1;
                end else begin
                    bad = 1;
                    m_und[k] = 1;
                end
            end
            if (bad) begin
                m_mis[k] = 1;
                if (m_err[k] < m_max[k]) m_err[k]++;
                if (m_limit[k] != 0 && m_err[k] == m_limit[k]) m_mode[k] = 2;
            end
            if (e && rdy) qpush(k, entry);
        end else begin
            m_cor[k] = 0; m_mis[k] = 0;
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("correct_a",   32'(cor_a),  32'(m_cor[0]));
        chk("mismatch_a",  32'(mis_a),  32'(m_mis[0]));
        chk("underflow_a", 32'(und_a),  32'(m_und[0]));
        chk("halted_a",    32'(hlt_a),  32'(m_mode[0] == 2));
        chk("match_cnt_a", 32'(mc_a),   32'(m_match[0]));
        chk("err_cnt_a",   32'(ec_a),   32'(m_err[0]));
        chk("pending_a",   32'(pend_a), 32'(qsize(0)));
        chk("correct_b",   32'(cor_b),  32'(m_cor[1]));
        chk("mismatch_b",  32'(mis_b),  32'(m_mis[1]));
        chk("underflow_b", 32'(und_b),  32'(m_und[1]));
        chk("halted_b",    32'(hlt_b),  32'(m_mode[1] == 2));
        chk("match_cnt_b", 32'(mc_b),   32'(m_match[1]));
        chk("err_cnt_b",   32'(ec_b),   32'(m_err[1]));
        chk("pending_b",   32'(pend_b), 32'(qsize(1)));
    endtask

    task automatic step(bit s, bit e, logic [15:0] d, logic [15:0] m, bit r, logic [15:0] res);
        bit rdy[2];
        logic [31:0] entry;
        @(negedge clk);
        start = s; ev = e; ed = d; rv = r; rd = res;
`ifdef CHECKER_MASK_EN
        em = m;
        entry = {m, d};
`else
        entry = {m | 16'hFFFF, d};
`endif
        #1;
        for (int k = 0; k < 2; k++)
            rdy[k] = (m_mode[k] == 1) && (qsize(k) < DEPTH || (r && qsize(k) > 0));
        chk("exp_ready_a", 32'(rdy_a), 32'(rdy[0]));
        chk("exp_ready_b", 32'(rdy_b), 32'(rdy[1]));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_update(k, s, e, entry, r, res, rdy[k]);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 16'hFFFF, 0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 0; ev = 0; rv = 0;
        @(posedge clk);
        #1;
        model_clear(0, 0);
        model_clear(1, 0);
        check_all();
        chk("reset_ready_a", 32'(rdy_a), 32'h0);
        chk("reset_ready_b", 32'(rdy_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] dat;
        logic [15:0] msk;

        // Reset state, and traffic ignored while idle
        do_reset();
        step(0, 1, 16'h0011, 16'hFFFF, 1, 16'h0011);

        // In-order stream with two-cycle result latency
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h0001, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h0002, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h0003, 16'hFFFF, 1, 16'h0001);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h0002);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h0003);
        chk("inorder_match_cnt", 32'(mc_a), 32'd3);
        chk("inorder_err_cnt",   32'(ec_a), 32'd0);
        chk("inorder_pending",   32'(pend_a), 32'd0);

        // Mismatch halts instance A; B keeps checking
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h00AA, 16'hFFFF, 0, 16'h0);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h00AB);
        chk("halt_flag", 32'(hlt_a), 32'h1);
        step(0, 1, 16'h0055, 16'hFFFF, 0, 16'h0);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h0055);
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        chk("restart_err_cnt", 32'(ec_a), 32'h0);

        // Full FIFO, then push+pop on the same cycle while full
        for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(16'h0100 + i), 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h0BAD, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h0108, 16'hFFFF, 1, 16'h0100);
        chk("full_pending", 32'(pend_a), 32'd8);
        for (int i = 1; i <= DEPTH; i++) step(0, 0, 16'h0, 16'hFFFF, 1, 16'(16'h0100 + i));

        // Underflow, and push+result while empty
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h0042);
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        step(0, 1, 16'h1234, 16'hFFFF, 1, 16'h1234);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h1234);

        // start_i discards same-cycle push and result
        step(0, 1, 16'h0077, 16'hFFFF, 0, 16'h0);
        step(1, 1, 16'h0078, 16'hFFFF, 1, 16'h0077);
        idle();

`ifdef CHECKER_MASK_EN
        step(0, 1, 16'h00F0, 16'hFF0F, 0, 16'h0);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h00A0);
        step(0, 1, 16'h00F0, 16'hFFFF, 0, 16'h0);
        step(0, 0, 16'h0, 16'hFFFF, 1, 16'h00A0);
`endif

        // Randomized traffic with periodic restarts; B saturates its 4-bit counters
        for (int i = 0; i < 480; i++) begin
            dat = 16'($urandom_range(255));
            msk = 16'hFFFF;
`ifdef CHECKER_MASK_EN
            msk = 16'($urandom);
`endif
            if (qb.size() > 0 && $urandom_range(7) != 0) res = qb[0][15:0];
            else                                         res = 16'($urandom_range(255));
            step((i % 80) == 0, $urandom_range(1) == 1, dat, msk, $urandom_range(2) != 0, res);
        end

        // Reset mid-stream
        step(1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 16'(16'h0200 + i), 16'hFFFF, 0, 16'h0);
        do_reset();
        step(0, 1, 16'h0200, 16'hFFFF, 1, 16'h0200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
